// File: rtl/prn_pkg.sv
// Shared definitions for the PRN transmit generator and the CDR-side checker.
// The PRBS is x^10 + x^7 + 1 in Fibonacci form: output is lfsr[9] and the
// feedback taps are bits 9 and 6.
package prn_pkg;

  localparam int PRN_W      = 10;
  localparam int PRN_PERIOD = 1023;
  localparam int PRN_TAP_HI = 9;
  localparam int PRN_TAP_LO = 6;

  localparam logic [PRN_W-1:0] PRN_ZERO_SUB = 10'h001;
  localparam logic [PRN_W-1:0] PRN_RESET    = 10'h3FF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } prn_state_t;

  // One Fibonacci shift: feedback enters at bit 0, the MSB leaves as the output bit.
  function automatic logic [PRN_W-1:0] prn_next(input logic [PRN_W-1:0] s);
    logic fb;
    fb = s[PRN_TAP_HI] ^ s[PRN_TAP_LO];
    return {s[PRN_W-2:0], fb};
  endfunction

endpackage

// File: rtl/prn_lfsr.sv
// 10-bit maximal-length LFSR register. A zero seed is swapped for
// PRN_ZERO_SUB so the all-zero lock-up state can never be entered.
module prn_lfsr
  import prn_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [PRN_W-1:0] seed,
  input  logic             step,
  output logic [PRN_W-1:0] state
);

  // Load has priority over step; reset restores the all-ones state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= PRN_RESET;
    end else if (load) begin
      state <= (seed == '0) ? PRN_ZERO_SUB : seed;
    end else if (step) begin
      state <= prn_next(state);
    end
  end

endmodule

// File: rtl/prn_tx_gen.sv
// PRBS transmit source: serialises the prn_lfsr sequence at one bit per OSR
// clocks with a bit strobe and a start-of-period marker.
// Optional feature macro: PRN_TX_ERR_INJ_EN adds err_inj / err_cnt and
// inverts the next transmitted bit on request.
//
// state | meaning
// IDLE  | stopped, lfsr/idx/ph held, dout shows the held bit
// LOAD  | seed captured this cycle, counters cleared
// RUN   | transmitting, ph counts, lfsr shifts at ph == OSR-1
module prn_tx_gen
  import prn_pkg::*;
#(
  parameter int OSR = 4
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [PRN_W-1:0] seed,
  input  logic             seed_load,
`ifdef PRN_TX_ERR_INJ_EN
  input  logic             err_inj,
  output logic [7:0]       err_cnt,
`endif
  output logic             dout,
  output logic             bit_stb,
  output logic             seq_start,
  output logic             busy
);

  localparam int PH_W = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(OSR - 1);
  localparam logic [PRN_W-1:0] IDX_LAST = PRN_W'(PRN_PERIOD - 1);

  prn_state_t       state_q;
  logic [PH_W-1:0]  ph_q;
  logic [PRN_W-1:0] idx_q;
  logic [PRN_W-1:0] lfsr_state;
  logic             bit_end;
  logic             lfsr_step;

  assign bit_end   = (state_q == RUN) && (ph_q == PH_LAST);
  // A seed_load on the last phase truncates the bit; the load wins.
  assign lfsr_step = bit_end && !seed_load;

  prn_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (seed_load),
    .seed  (seed),
    .step  (lfsr_step),
    .state (lfsr_state)
  );

  // Sequencing FSM with phase and bit-index counters; seed_load beats everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      ph_q    <= '0;
      idx_q   <= '0;
    end else if (seed_load) begin
      state_q <= LOAD;
      ph_q    <= '0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en) state_q <= RUN;
        end
        LOAD: begin
          state_q <= en ? RUN : IDLE;
        end
        RUN: begin
          if (ph_q == PH_LAST) begin
            ph_q  <= '0;
            idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + PRN_W'(1);
            if (!en) state_q <= IDLE;
          end else begin
            ph_q <= ph_q + PH_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bit_stb   = (state_q == RUN) && (ph_q == '0);
  assign seq_start = bit_stb && (idx_q == '0);
  assign busy      = (state_q == LOAD) || (state_q == RUN);

`ifdef PRN_TX_ERR_INJ_EN
  logic       err_pend_q;
  logic       err_inv_q;
  logic [7:0] err_cnt_q;
  logic       err_take;

  // A request arriving on the last phase still targets the very next bit.
  assign err_take = err_pend_q || err_inj;

  // Latch requests during a bit, then invert the whole following bit and count it once.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_pend_q <= 1'b0;
      err_inv_q  <= 1'b0;
      err_cnt_q  <= 8'd0;
    end else if (seed_load) begin
      err_pend_q <= 1'b0;
      err_inv_q  <= 1'b0;
    end else if (bit_end) begin
      err_inv_q  <= err_take;
      err_pend_q <= 1'b0;
      if (err_take && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
    end else if ((state_q == RUN) && err_inj) begin
      err_pend_q <= 1'b1;
    end
  end

  assign dout    = lfsr_state[PRN_W-1] ^ err_inv_q;
  assign err_cnt = err_cnt_q;
`else
  assign dout = lfsr_state[PRN_W-1];
`endif

endmodule
